// File: rtl/wb_csr_commit.sv
// WB-stage commit: latches one MEM instruction, drives CSR access,
// exception/ertn reports, GPR writeback and the pre-IF redirect handshake.
// Ports: ms_* in from MEM; csr_*/wb_*/ertn_flush to CSR file;
// rf_* to GPR file; flush_* handshake to pre-IF; inst_retired counter.
module wb_csr_commit #(
  parameter logic [31:0] RESET_PC_UNUSED = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic        ms_csr,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rj_value,
  input  logic [31:0] ms_rd_value,
  input  logic        ms_ex,
  input  logic [5:0]  ms_ecode,
  input  logic [8:0]  ms_esubcode,
  input  logic        ms_ertn,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic        ertn_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_flush_pipe,
  output logic        flush_valid,
  output logic [31:0] flush_target,
  input  logic        flush_ready,
  output logic [31:0] inst_retired
);

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_csr;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value;
  logic [31:0] ws_rd_value;
  logic        ws_ex;
  logic [5:0]  ws_ecode;
  logic [8:0]  ws_esubcode;
  logic        ws_ertn;
  logic        ws_gr_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result;
  logic [31:0] retired_q;

  logic commit;
  logic commit_redirect;
  logic ws_load;
  logic csr_acc;
  logic is_wr;
  logic is_xchg;

  assign ws_allowin      = 1'b1;
  assign commit          = ws_valid && (state == RUN);
  assign commit_redirect = commit && (ws_ex || ws_ertn);
  assign ws_flush_pipe   = commit_redirect || (state == REDIRECT);
  // While flushing, MEM entries are taken and dropped.
  assign ws_load         = ms_to_ws_valid && !ws_flush_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ws_valid    <= 1'b0;
      ws_pc       <= RESET_PC_UNUSED;
      ws_csr      <= 1'b0;
      ws_csr_op   <= 2'b00;
      ws_csr_num  <= 14'd0;
      ws_rj_value <= 32'd0;
      ws_rd_value <= 32'd0;
      ws_ex       <= 1'b0;
      ws_ecode    <= 6'd0;
      ws_esubcode <= 9'd0;
      ws_ertn     <= 1'b0;
      ws_gr_we    <= 1'b0;
      ws_dest     <= 5'd0;
      ws_result   <= 32'd0;
    end else begin
      ws_valid <= ws_load;
      if (ws_load) begin
        ws_pc       <= ms_pc;
        ws_csr      <= ms_csr;
        ws_csr_op   <= ms_csr_op;
        ws_csr_num  <= ms_csr_num;
        ws_rj_value <= ms_rj_value;
        ws_rd_value <= ms_rd_value;
        ws_ex       <= ms_ex;
        ws_ecode    <= ms_ecode;
        ws_esubcode <= ms_esubcode;
        ws_ertn     <= ms_ertn;
        ws_gr_we    <= ms_gr_we;
        ws_dest     <= ms_dest;
        ws_result   <= ms_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (commit_redirect) state_nxt = REDIRECT;
      REDIRECT: if (flush_ready)     state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  flush_target <= 32'd0;
    else if (commit_redirect) flush_target <= ws_ex ? ex_entry : ertn_pc;
  end

  assign flush_valid = (state == REDIRECT);

  // Exception outranks ertn, which outranks CSR/GPR side effects.
  assign wb_ex       = commit && ws_ex;
  assign wb_ecode    = ws_ecode;
  assign wb_esubcode = ws_esubcode;
  assign wb_pc       = ws_pc;
  assign ertn_flush  = commit && ws_ertn && !ws_ex;

  assign is_wr   = (ws_csr_op == 2'b01);
  assign is_xchg = (ws_csr_op == 2'b10);
  assign csr_acc = commit && ws_csr && !ws_ex && !ws_ertn;

  always_comb begin
    csr_wmask = 32'd0;
    unique case (1'b1)
      is_xchg: csr_wmask = ws_rj_value;
      is_wr:   csr_wmask = 32'hFFFF_FFFF;
      default: csr_wmask = 32'd0;
    endcase
    if (!csr_we) csr_wmask = 32'd0;
  end

  assign csr_re     = csr_acc;
  assign csr_we     = csr_acc && (is_wr || is_xchg);
  assign csr_num    = csr_acc ? ws_csr_num : 14'd0;
  assign csr_wvalue = csr_we ? ws_rd_value : 32'd0;

  // CSR read returns the pre-write value in the same cycle.
  assign rf_we    = commit && ws_gr_we && !ws_ex && !ws_ertn
                    && (ws_dest != 5'd0);
  assign rf_waddr = ws_dest;
  assign rf_wdata = ws_csr ? csr_rvalue : ws_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  retired_q <= 32'd0;
    else if (commit && !ws_ex) retired_q <= retired_q + 32'd1;
  end

  assign inst_retired = retired_q;

endmodule

// File: tb/tb_wb_csr_commit.sv
// Bench for wb_csr_commit: scoreboard of predicted commit outputs,
// CSR file model behind the csr_* port, redirect and reset scenarios.
module tb_wb_csr_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_csr;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rj_value;
  logic [31:0] ms_rd_value;
  logic        ms_ex;
  logic [5:0]  ms_ecode;
  logic [8:0]  ms_esubcode;
  logic        ms_ertn;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic [31:0] ex_entry;
  logic [31:0] ertn_pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_flush_pipe;
  logic        flush_valid;
  logic [31:0] flush_target;
  logic        flush_ready;
  logic [31:0] inst_retired;

  wb_csr_commit dut (
    .clk(clk), .rst(rst),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_csr(ms_csr), .ms_csr_op(ms_csr_op),
    .ms_csr_num(ms_csr_num), .ms_rj_value(ms_rj_value),
    .ms_rd_value(ms_rd_value), .ms_ex(ms_ex), .ms_ecode(ms_ecode),
    .ms_esubcode(ms_esubcode), .ms_ertn(ms_ertn),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_pc(wb_pc), .ertn_flush(ertn_flush),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_flush_pipe(ws_flush_pipe), .flush_valid(flush_valid),
    .flush_target(flush_target), .flush_ready(flush_ready),
    .inst_retired(inst_retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        csr;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rd;
    logic        ex;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        ertn;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } in_t;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic        flush_pipe;
    logic        flush_valid;
    logic [31:0] retired;
  } obs_t;

  // CSR file seen by the DUT; 16 entries indexed by csr_num[3:0].
  logic [31:0] csr_mem [0:15];
  assign csr_rvalue = csr_mem[csr_num[3:0]];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) csr_mem[k] <= 32'hC0DE0000 | k;
    end else if (csr_we) begin
      csr_mem[csr_num[3:0]] <= (csr_mem[csr_num[3:0]] & ~csr_wmask)
                               | (csr_wvalue & csr_wmask);
    end
  end

  logic [31:0] exp_csr [0:15];
  logic [31:0] exp_ret;
  obs_t        sb [$];
  int          n_chk = 0;
  int          n_fail = 0;
  obs_t        e, o;

  function automatic void init_model();
    for (int k = 0; k < 16; k++) exp_csr[k] = 32'hC0DE0000 | k;
    exp_ret = 32'd0;
  endfunction

  function automatic obs_t predict(in_t i);
    obs_t r;
    logic acc, we;
    logic [3:0] idx;
    acc = i.csr && !i.ex && !i.ertn;
    we  = acc && (i.op == 2'b01 || i.op == 2'b10);
    idx = acc ? i.num[3:0] : 4'd0;
    r.rf_we       = i.gr_we && !i.ex && !i.ertn && (i.dest != 5'd0);
    r.rf_waddr    = i.dest;
    r.rf_wdata    = i.csr ? exp_csr[idx] : i.result;
    r.csr_re      = acc;
    r.csr_we      = we;
    r.csr_num     = acc ? i.num : 14'd0;
    r.csr_wmask   = !we ? 32'd0 : (i.op == 2'b10 ? i.rj : 32'hFFFFFFFF);
    r.csr_wvalue  = we ? i.rd : 32'd0;
    r.wb_ex       = i.ex;
    r.wb_ecode    = i.ecode;
    r.wb_esubcode = i.esub;
    r.wb_pc       = i.pc;
    r.ertn_flush  = i.ertn && !i.ex;
    r.flush_pipe  = i.ex || i.ertn;
    r.flush_valid = 1'b0;
    r.retired     = exp_ret;
    if (we) exp_csr[idx] = (exp_csr[idx] & ~r.csr_wmask)
                           | (i.rd & r.csr_wmask);
    if (!i.ex) exp_ret = exp_ret + 32'd1;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.rf_we       = rf_we;
    r.rf_waddr    = rf_waddr;
    r.rf_wdata    = rf_wdata;
    r.csr_re      = csr_re;
    r.csr_we      = csr_we;
    r.csr_num     = csr_num;
    r.csr_wmask   = csr_wmask;
    r.csr_wvalue  = csr_wvalue;
    r.wb_ex       = wb_ex;
    r.wb_ecode    = wb_ecode;
    r.wb_esubcode = wb_esubcode;
    r.wb_pc       = wb_pc;
    r.ertn_flush  = ertn_flush;
    r.flush_pipe  = ws_flush_pipe;
    r.flush_valid = flush_valid;
    r.retired     = inst_retired;
    return r;
  endfunction

  function automatic in_t mk(logic [31:0] pc, logic csr, logic [1:0] op,
                             logic [13:0] num, logic [31:0] rj,
                             logic [31:0] rd, logic ex, logic ertn,
                             logic gr_we, logic [4:0] dest,
                             logic [31:0] result);
    in_t i;
    i = '0;
    i.pc = pc; i.csr = csr; i.op = op; i.num = num; i.rj = rj;
    i.rd = rd; i.ex = ex; i.ecode = 6'h0B; i.esub = 9'h003;
    i.ertn = ertn; i.gr_we = gr_we; i.dest = dest; i.result = result;
    return i;
  endfunction

  task automatic drive(in_t i);
    ms_to_ws_valid = 1'b1;
    ms_pc = i.pc; ms_csr = i.csr; ms_csr_op = i.op;
    ms_csr_num = i.num; ms_rj_value = i.rj; ms_rd_value = i.rd;
    ms_ex = i.ex; ms_ecode = i.ecode; ms_esubcode = i.esub;
    ms_ertn = i.ertn; ms_gr_we = i.gr_we; ms_dest = i.dest;
    ms_result = i.result;
  endtask

  task automatic send(in_t i);
    drive(i);
    sb.push_back(predict(i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A younger csrwr that must never take effect while flushing.
  function automatic in_t younger();
    return mk(32'h1c000200, 1'b1, 2'b01, 14'h0032, 32'h0,
              32'h77777777, 1'b0, 1'b0, 1'b1, 5'd12, 32'h99);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    ms_to_ws_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    ms_to_ws_valid = 1'b0;
    flush_ready = 1'b0;
    ex_entry = 32'h1c008000;
    ertn_pc = 32'h1c000104;
    init_model();
    #12;
    n_chk++;
    if (flush_valid !== 1'b0 || flush_target !== 32'd0
        || ws_flush_pipe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flush valid=%b tgt=%h pipe=%b req 0/0/0",
               flush_valid, flush_target, ws_flush_pipe);
    end
    n_chk++;
    if ({rf_we, csr_we, csr_re, wb_ex, ertn_flush} !== 5'b0
        || ws_allowin !== 1'b1 || inst_retired !== 32'd0
        || wb_pc !== 32'h1c000000) begin
      n_fail++;
      $display("FAIL reset_outs en=%b allow=%b ret=%h pc=%h",
               {rf_we, csr_we, csr_re, wb_ex, ertn_flush},
               ws_allowin, inst_retired, wb_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_csrwr();
    send(mk(32'h1c000010, 1'b1, 2'b01, 14'h0030, 32'h0,
            32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0));
    step();
    send(mk(32'h1c000014, 1'b1, 2'b00, 14'h0030, 32'h0,
            32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0));
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL csrwr got=%h want=%h", o, e);
    end
    step();
    ms_to_ws_valid = 1'b0;
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL csrrd_after_wr got=%h want=%h", o, e);
    end
    step();
  endtask

  task automatic test_csrxchg();
    send(mk(32'h1c000020, 1'b1, 2'b10, 14'h0031, 32'h0000FF00,
            32'h12345678, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0));
    step();
    send(mk(32'h1c000024, 1'b1, 2'b11, 14'h0031, 32'hFFFFFFFF,
            32'h0BADF00D, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0));
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL csrxchg got=%h want=%h", o, e);
    end
    step();
    send(mk(32'h1c000028, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
            1'b0, 1'b0, 1'b1, 5'd0, 32'hCAFE0000));
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL csr_op11 got=%h want=%h", o, e);
    end
    step();
    send(mk(32'h1c00002c, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
            1'b0, 1'b0, 1'b1, 5'd3, 32'h13572468));
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL gpr_dest0 got=%h want=%h", o, e);
    end
    step();
    ms_to_ws_valid = 1'b0;
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL gpr_alu got=%h want=%h", o, e);
    end
    step();
  endtask

  task automatic test_exception();
    flush_ready = 1'b0;
    ex_entry = 32'h1c008000;
    send(mk(32'h1c000100, 1'b1, 2'b01, 14'h0030, 32'h0,
            32'h11111111, 1'b1, 1'b0, 1'b1, 5'd9, 32'h5));
    step();
    drive(younger());
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL ex_commit got=%h want=%h", o, e);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (flush_valid !== 1'b1 || flush_target !== 32'h1c008000
          || ws_flush_pipe !== 1'b1 || wb_ex !== 1'b0
          || rf_we !== 1'b0 || csr_we !== 1'b0) begin
        n_fail++;
        $display("FAIL ex_hold%0d fv=%b tgt=%h pipe=%b ex=%b rf=%b cw=%b",
                 k, flush_valid, flush_target, ws_flush_pipe,
                 wb_ex, rf_we, csr_we);
      end
    end
    flush_ready = 1'b1;
    step();
    n_chk++;
    if (flush_valid !== 1'b0 || rf_we !== 1'b0 || csr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_release fv=%b rf=%b cw=%b req 0/0/0",
               flush_valid, rf_we, csr_we);
    end
    ms_to_ws_valid = 1'b0;
    flush_ready = 1'b0;
    step();
    n_chk++;
    if (inst_retired !== exp_ret || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ex_count ret=%h want=%h rf=%b",
               inst_retired, exp_ret, rf_we);
    end
  endtask

  task automatic test_ertn();
    flush_ready = 1'b0;
    ertn_pc = 32'h1c000104;
    send(mk(32'h1c000300, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
            1'b0, 1'b1, 1'b1, 5'd8, 32'h44));
    step();
    drive(younger());
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL ertn_commit got=%h want=%h", o, e);
    end
    step();
    n_chk++;
    if (flush_valid !== 1'b1 || flush_target !== 32'h1c000104
        || ertn_flush !== 1'b0 || rf_we !== 1'b0 || csr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ertn_hold fv=%b tgt=%h ef=%b rf=%b cw=%b",
               flush_valid, flush_target, ertn_flush, rf_we, csr_we);
    end
    flush_ready = 1'b1;
    step();
    ms_to_ws_valid = 1'b0;
    flush_ready = 1'b0;
    n_chk++;
    if (flush_valid !== 1'b0 || rf_we !== 1'b0 || csr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL ertn_release fv=%b rf=%b cw=%b",
               flush_valid, rf_we, csr_we);
    end
    step();
    n_chk++;
    if (inst_retired !== exp_ret || csr_mem[2] !== exp_csr[2]) begin
      n_fail++;
      $display("FAIL ertn_count ret=%h want=%h csr2=%h want=%h",
               inst_retired, exp_ret, csr_mem[2], exp_csr[2]);
    end
  endtask

  task automatic test_reset_redirect();
    flush_ready = 1'b0;
    send(mk(32'h1c000400, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
            1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
    step();
    ms_to_ws_valid = 1'b0;
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL rr_commit got=%h want=%h", o, e);
    end
    step();
    n_chk++;
    if (flush_valid !== 1'b1) begin
      n_fail++; $display("FAIL rr_enter fv=%b want 1", flush_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    init_model();
    n_chk++;
    if (flush_valid !== 1'b0 || ws_flush_pipe !== 1'b0
        || flush_target !== 32'd0 || inst_retired !== 32'd0) begin
      n_fail++;
      $display("FAIL rr_async fv=%b pipe=%b tgt=%h ret=%h req 0",
               flush_valid, ws_flush_pipe, flush_target, inst_retired);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 32'hFFFFFFFF;
    step();
    flush_ready = 1'b1;
    send(mk(32'h1c000500, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
            1'b0, 1'b0, 1'b1, 5'd10, 32'h55));
    step();
    send(mk(32'h1c000504, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
            1'b1, 1'b0, 1'b1, 5'd11, 32'h66));
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL wrap_commit got=%h want=%h", o, e);
    end
    step();
    ms_to_ws_valid = 1'b0;
    e = sb.pop_front(); o = sample(); n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL wrap_ex got=%h want=%h", o, e);
    end
    step();
    step();
    n_chk++;
    if (inst_retired !== 32'd0 || exp_ret !== 32'd0
        || flush_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_count ret=%h model=%h fv=%b req 0",
               inst_retired, exp_ret, flush_valid);
    end
    flush_ready = 1'b0;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain left=%0d want 0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_csrwr();
    test_csrxchg();
    test_exception();
    test_ertn();
    test_reset_redirect();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
